// File: rtl/route_replayer.sv
// Records a turn-by-turn route from the explorer and replays it one turn per junction.
// Optional line-lost timeout is compiled in with `define ROUTE_LOST_TIMEOUT_EN.
module route_replayer #(
    parameter int DEPTH      = 16,
    parameter int LOST_LIMIT = 50_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rec_valid,
    input  logic [1:0]               rec_dir,
    output logic                     rec_ready,
    input  logic                     rec_pop,
    input  logic                     replay_start,
    input  logic [2:0]               detect,
    output logic [1:0]               turn_cmd,
    output logic                     turn_valid,
    input  logic                     turn_ack,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_JCT, S_ISSUE, S_DONE, S_ERROR} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   rd_q, rd_d;
    logic            zero_done_q, zero_done_d;
    logic [2:0]      det_q;
    logic [1:0]      mem_q [DEPTH];
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            push, pop, junction, lost;

    assign push     = (state_q == S_IDLE) && rec_valid && (count_q < DEPTH_C) && (rec_dir != 2'b11);
    assign pop      = (state_q == S_IDLE) && rec_pop && (count_q != '0);
    assign junction = (detect == 3'b111) && (det_q != 3'b111);
    assign count    = count_q;

`ifdef ROUTE_LOST_TIMEOUT_EN
    localparam int LW = $clog2(LOST_LIMIT + 1);
    logic [LW-1:0] lost_q;

    assign lost = (state_q == S_WAIT_JCT) && (detect == 3'b000) && (lost_q == LW'(LOST_LIMIT - 1));
    assign err  = (state_q == S_ERROR);

    always_ff @(posedge clk) begin
        if (!rst || state_q != S_WAIT_JCT || detect != 3'b000)
            lost_q <= '0;
        else
            lost_q <= lost_q + 1'b1;
    end
`else
    assign lost = 1'b0;
    assign err  = 1'b0;
`endif

    // State register (plus replay index and empty-replay done pulse)
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rd_q        <= '0;
            zero_done_q <= 1'b0;
            det_q       <= 3'b000;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            zero_done_q <= zero_done_d;
            det_q       <= detect;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        zero_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (replay_start) begin
                    if (count_q != '0) begin
                        rd_d    = '0;
                        state_d = S_WAIT_JCT;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            S_WAIT_JCT: begin
                if (lost)
                    state_d = S_ERROR;
                else if (junction)
                    state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (turn_ack) begin
                    rd_d    = rd_q + 1'b1;
                    state_d = (rd_q + 1'b1 == count_q) ? S_DONE : S_WAIT_JCT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rec_ready  = (state_q == S_IDLE) && (count_q < DEPTH_C);
        turn_valid = (state_q == S_ISSUE);
        turn_cmd   = (state_q == S_ISSUE) ? mem_q[rd_q[AW-1:0]] : 2'b00;
        busy       = (state_q == S_WAIT_JCT) || (state_q == S_ISSUE);
        done       = (state_q == S_DONE) || zero_done_q;
    end

    // Push+pop together replaces the newest entry instead of growing the route
    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = count_q[AW-1:0];
        if (push && pop) begin
            wr_en   = 1'b1;
            wr_addr = AW'(count_q - 1'b1);
        end else if (push) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
        end else if (pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_addr] <= rec_dir;
    end
endmodule

// File: tb/tb_route_replayer.sv
// Randomized and directed bench for route_replayer against a queue-based route model.
module tb_route_replayer;
    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic       rec_valid;
    logic [1:0] rec_dir;
    logic       rec_ready;
    logic       rec_pop;
    logic       replay_start;
    logic [2:0] detect;
    logic [1:0] turn_cmd;
    logic       turn_valid;
    logic       turn_ack;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] count;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] route [$];

    route_replayer #(.DEPTH(DEPTH), .LOST_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .rec_valid(rec_valid), .rec_dir(rec_dir), .rec_ready(rec_ready), .rec_pop(rec_pop),
        .replay_start(replay_start), .detect(detect),
        .turn_cmd(turn_cmd), .turn_valid(turn_valid), .turn_ack(turn_ack),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        route.delete();
    endtask

    // One recording cycle in IDLE; the model applies the push/pop rules to the route queue
    task automatic drive_rec(input bit v, input logic [1:0] d, input bit p);
        check("rec_ready", rec_ready, route.size() < DEPTH);
        rec_valid = v;
        rec_dir   = d;
        rec_pop   = p;
        if (v && route.size() < DEPTH && d != 2'b11) begin
            if (p && route.size() > 0)
                route[route.size()-1] = d;
            else
                route.push_back(d);
        end else if (p && route.size() > 0) begin
            void'(route.pop_back());
        end
        tick();
        rec_valid = 1'b0;
        rec_pop   = 1'b0;
        check("count", count, route.size());
    endtask

    task automatic replay;
        replay_start = 1'b1;
        tick();
        replay_start = 1'b0;
        if (route.size() == 0) begin
            check("empty_done", done, 1);
            check("empty_busy", busy, 0);
            tick();
            check("empty_done_end", done, 0);
            return;
        end
        check("replay_busy", busy, 1);
        for (int i = 0; i < route.size(); i++) begin
            rec_valid = 1'($urandom);
            rec_pop   = 1'($urandom);
            rec_dir   = 2'($urandom);
            detect    = 3'b000;
            tick();
            rec_valid = 1'b0;
            rec_pop   = 1'b0;
            check("no_early_issue", turn_valid, 0);
            check("idle_cmd", turn_cmd, 0);
            detect = 3'b111;
            tick();
            check("issue_valid", turn_valid, 1);
            check("issue_cmd", turn_cmd, route[i]);
            tick();
            check("issue_cmd_hold", turn_cmd, route[i]);
            turn_ack = 1'b1;
            tick();
            turn_ack = 1'b0;
            check("ack_drop", turn_valid, 0);
        end
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        detect = 3'b000;
        tick();
        check("done_once", done, 0);
        check("count_kept", count, route.size());
    endtask

    initial begin
        int held;
        int issues;
        bit prev;

        rst = 1'b0; rec_valid = 1'b0; rec_dir = 2'b00; rec_pop = 1'b0;
        replay_start = 1'b0; detect = 3'b000; turn_ack = 1'b0;
        tick();
        tick();
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_tvalid", turn_valid, 0);
        check("rst_tcmd", turn_cmd, 0);
        rst = 1'b1;
        tick();
        check("rec_ready_after_rst", rec_ready, 1);

        // Empty replay: done pulse only
        replay();

        // Basic three-turn route
        drive_rec(1, 2'b01, 0);
        drive_rec(1, 2'b10, 0);
        drive_rec(1, 2'b00, 0);
        replay();

        // Fill to capacity, overflow, drain, underflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive_rec(1, 2'($urandom_range(0, 2)), 0);
        drive_rec(1, 2'b01, 0);
        for (int i = 0; i <= DEPTH; i++) drive_rec(0, 2'b00, 1);
        check("drained", count, 0);

        // Push with simultaneous pop replaces newest; reserved code dropped
        drive_rec(1, 2'b01, 0);
        drive_rec(1, 2'b10, 1);
        check("replace_count", count, 1);
        drive_rec(1, 2'b11, 0);
        replay();

        // Held junction gives exactly one issue; unacked turn stays stable
        do_reset();
        drive_rec(1, 2'b01, 0);
        drive_rec(1, 2'b10, 0);
        replay_start = 1'b1;
        tick();
        replay_start = 1'b0;
        detect = 3'b111;
        held = 0; issues = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (turn_valid) begin
                if (!prev) issues++;
                held++;
                check("held_cmd", turn_cmd, 2'b01);
            end
            prev = turn_valid;
            turn_ack = (turn_valid && held == 6);
        end
        turn_ack = 1'b0;
        check("single_issue", issues, 1);
        check("held_cycles", held, 6);
        check("held_busy", busy, 1);
        detect = 3'b000;
        tick();
        detect = 3'b111;
        tick();
        check("second_cmd", turn_cmd, 2'b10);
        turn_ack = 1'b1;
        tick();
        turn_ack = 1'b0;
        check("second_done", done, 1);
        detect = 3'b000;
        tick();

        // Line lost: 8 cycles of 000 while waiting for a junction
        do_reset();
        drive_rec(1, 2'b01, 0);
        replay_start = 1'b1;
        tick();
        replay_start = 1'b0;
        detect = 3'b000;
        for (int i = 0; i < 7; i++) tick();
        check("err_before_limit", err, 0);
        tick();
`ifdef ROUTE_LOST_TIMEOUT_EN
        check("lost_err", err, 1);
        check("lost_busy", busy, 0);
        check("lost_tvalid", turn_valid, 0);
        tick();
        check("err_sticky", err, 1);
`else
        check("no_timeout_err", err, 0);
        check("no_timeout_busy", busy, 1);
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1;
        route.delete();
        check("err_cleared", err, 0);
        check("count_cleared", count, 0);

        // Reset during ISSUE abandons the replay
        drive_rec(1, 2'b10, 0);
        drive_rec(1, 2'b01, 0);
        replay_start = 1'b1;
        tick();
        replay_start = 1'b0;
        tick();
        detect = 3'b111;
        tick();
        check("pre_rst_issue", turn_valid, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        route.delete();
        check("rst_issue_tvalid", turn_valid, 0);
        check("rst_issue_busy", busy, 0);
        check("rst_issue_count", count, 0);
        detect = 3'b000;
        tick();
        detect = 3'b111;
        tick();
        check("no_issue_after_rst", turn_valid, 0);
        detect = 3'b000;
        tick();

        // Random record/backtrack sequences followed by replay
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 50; c++)
                drive_rec(($urandom % 4) != 0, 2'($urandom), ($urandom % 4) == 0);
            replay();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
